// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-path types and instruction ROM image
//
// Purpose: widths, word types and the fetch entry carried from fetch to decode.
// rom_image() defines the contents of the instruction ROM: word = {addr, ~addr}.
package cpu_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;

  typedef logic [ADDR_W-1:0]  pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef struct packed {
    instr_t instr;
    pc_t    pc;
  } fetch_entry_t;

  function automatic instr_t rom_image(input pc_t a);
    return {a, ~a};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of fetch entries with flush
//
// Purpose: buffers fetched {instr, pc} entries ahead of decode.
// Ports:
//   i_clk    clock, all state on posedge
//   i_rst_n  synchronous active-low reset (clears storage, pointers, count)
//   i_flush  drops all entries (pointers/count to 0), priority over push/pop
//   i_push   write i_data at the tail; caller guarantees a free slot
//   i_data   entry to write
//   i_pop    advance the head; ignored while empty
//   o_head   entry at the head
//   o_count  number of stored entries
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  fetch_entry_t     i_data,
  input  logic             i_pop,
  output fetch_entry_t     o_head,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_pop = i_pop & (r_count != '0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      // Cleared so the head reads as zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC in, {instr, pc} out to decode
//
// Purpose: registers ROM[pc_in] into stage S1 on accept, then retires S1 into an
// output FIFO that absorbs decode back-pressure. A FIFO slot is reserved for the
// S1 entry before accepting, so pc_ready never depends on instr_ready.
// Ports:
//   sysclk       clock
//   rst_n        synchronous active-low reset
//   pc_in        fetch address           pc_valid / pc_ready   accept handshake
//   flush        drop S1 and FIFO contents (fetch_count kept)
//   instr_out    head instruction        instr_pc              head PC
//   instr_valid  head entry valid        instr_ready           decode pops head
//   fetch_count  pops delivered, 16-bit wrapping
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 3
) (
  input  logic               sysclk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               pc_valid,
  output logic               pc_ready,
  input  logic               flush,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [15:0]        fetch_count
);

  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int ROM_SIZE = 2 ** ADDR_W;

  instr_t           w_rom [ROM_SIZE];
  logic             r_s1_valid;
  fetch_entry_t     r_s1_entry;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W:0]   w_occupancy;
  fetch_entry_t     w_head;
  logic             w_acc;
  logic             w_pop;
  logic [15:0]      r_fetch_count;

  for (genvar g = 0; g < ROM_SIZE; g++) begin : g_rom
    assign w_rom[g] = rom_image(pc_t'(g));
  end

  // Buffered entries plus the one in flight in S1 must leave room for a new accept.
  assign w_occupancy = {1'b0, w_count} + {{CNT_W{1'b0}}, r_s1_valid};
  assign pc_ready    = rst_n & ~flush & (w_occupancy < (CNT_W + 1)'(FIFO_DEPTH));
  assign w_acc       = pc_valid & pc_ready;

  assign instr_valid = (w_count != '0);
  assign w_pop       = instr_valid & instr_ready;

  // One-cycle synchronous ROM read into S1.
  always_ff @(posedge sysclk) begin
    if (!rst_n || flush) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_acc;
    end
    if (w_acc) begin
      r_s1_entry <= '{instr: w_rom[pc_in], pc: pc_in};
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .i_clk   (sysclk),
    .i_rst_n (rst_n),
    .i_flush (flush),
    .i_push  (r_s1_valid),
    .i_data  (r_s1_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // A pop coinciding with flush is discarded, so it is not counted.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_fetch_count <= '0;
    end else if (w_pop && !flush) begin
      r_fetch_count <= r_fetch_count + 16'd1;
    end
  end

  assign instr_out   = w_head.instr;
  assign instr_pc    = w_head.pc;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;

  logic        sysclk = 1'b0;
  logic        rst_n;
  logic [7:0]  pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic [15:0] instr_out;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] fetch_count;

  int   n_checks = 0;
  int   n_errors = 0;
  logic acc;
  logic exp_v;

  always #5 sysclk = ~sysclk;

  instruction_fetch #(.FIFO_DEPTH(3)) dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .pc_in       (pc_in),
    .pc_valid    (pc_valid),
    .pc_ready    (pc_ready),
    .flush       (flush),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .fetch_count (fetch_count)
  );

  function automatic logic [15:0] img(input logic [7:0] a);
    return {a, ~a};
  endfunction

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pc_valid = 1'b1; pc_in = 8'h00; flush = 1'b0; instr_ready = 1'b0;
    #1;
    n_checks++; if (pc_ready !== 1'b0) begin n_errors++; $display("FAIL reset_pc_ready_pre: got %b want 0", pc_ready); end
    tick(); tick();
    n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    n_checks++; if (instr_out !== 16'h0000) begin n_errors++; $display("FAIL reset_instr: got %h want 0000", instr_out); end
    n_checks++; if (instr_pc !== 8'h00) begin n_errors++; $display("FAIL reset_pc: got %h want 00", instr_pc); end
    n_checks++; if (fetch_count !== 16'd0) begin n_errors++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
    n_checks++; if (pc_ready !== 1'b0) begin n_errors++; $display("FAIL reset_pc_ready: got %b want 0", pc_ready); end
    pc_valid = 1'b0; rst_n = 1'b1;
    #1;
    n_checks++; if (pc_ready !== 1'b1) begin n_errors++; $display("FAIL reset_release_ready: got %b want 1", pc_ready); end
  endtask

  task automatic test_streaming();
    instr_ready = 1'b1; pc_in = 8'h00; pc_valid = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_v = (i >= 1 && i <= 10);
      n_checks++; if (instr_valid !== exp_v) begin n_errors++; $display("FAIL stream_valid[%0d]: got %b want %b", i, instr_valid, exp_v); end
      if (exp_v) begin
        n_checks++; if (instr_pc !== 8'(i - 1)) begin n_errors++; $display("FAIL stream_pc[%0d]: got %h want %h", i, instr_pc, 8'(i - 1)); end
        n_checks++; if (instr_out !== img(8'(i - 1))) begin n_errors++; $display("FAIL stream_instr[%0d]: got %h want %h", i, instr_out, img(8'(i - 1))); end
      end
      pc_in = 8'(i + 1); pc_valid = (i + 1 <= 9);
      #1;
      n_checks++; if (pc_ready !== 1'b1) begin n_errors++; $display("FAIL stream_ready[%0d]: got %b want 1", i, pc_ready); end
    end
    n_checks++; if (fetch_count !== 16'd10) begin n_errors++; $display("FAIL stream_count: got %0d want 10", fetch_count); end
  endtask

  task automatic test_back_pressure();
    instr_ready = 1'b0; pc_in = 8'h00; pc_valid = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_v = (i >= 1);
      n_checks++; if (instr_valid !== exp_v) begin n_errors++; $display("FAIL bp_valid[%0d]: got %b want %b", i, instr_valid, exp_v); end
      if (exp_v) begin
        n_checks++; if (instr_pc !== 8'h00) begin n_errors++; $display("FAIL bp_hold_pc[%0d]: got %h want 00", i, instr_pc); end
        n_checks++; if (instr_out !== 16'h00FF) begin n_errors++; $display("FAIL bp_hold_instr[%0d]: got %h want 00ff", i, instr_out); end
      end
      pc_in = (i < 2) ? 8'(i + 1) : 8'd3;
      #1;
      exp_v = (i < 2);
      n_checks++; if (pc_ready !== exp_v) begin n_errors++; $display("FAIL bp_ready[%0d]: got %b want %b", i, pc_ready, exp_v); end
    end
    instr_ready = 1'b1;
    #1;
    n_checks++; if (pc_ready !== 1'b0) begin n_errors++; $display("FAIL bp_ready_no_comb: got %b want 0", pc_ready); end
    acc = pc_valid & pc_ready;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (acc) pc_in = pc_in + 8'd1;
      pc_valid = (pc_in <= 8'd9);
      n_checks++; if (instr_valid !== 1'b1) begin n_errors++; $display("FAIL bp_drain_valid[%0d]: got %b want 1", k, instr_valid); end
      n_checks++; if (instr_pc !== 8'(k + 1)) begin n_errors++; $display("FAIL bp_order_pc[%0d]: got %h want %h", k, instr_pc, 8'(k + 1)); end
      n_checks++; if (instr_out !== img(8'(k + 1))) begin n_errors++; $display("FAIL bp_order_instr[%0d]: got %h want %h", k, instr_out, img(8'(k + 1))); end
      #1;
      acc = pc_valid & pc_ready;
    end
    tick();
    n_checks++; if (instr_pc !== 8'd9 || instr_valid !== 1'b1) begin n_errors++; $display("FAIL bp_last: got valid %b pc %h want 1 09", instr_valid, instr_pc); end
    tick();
    n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL bp_empty: got %b want 0", instr_valid); end
    n_checks++; if (fetch_count !== 16'd20) begin n_errors++; $display("FAIL bp_count: got %0d want 20", fetch_count); end
  endtask

  task automatic test_flush();
    instr_ready = 1'b0; pc_in = 8'h10; pc_valid = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      pc_in = 8'(8'h11 + i);
    end
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 8'h10) begin n_errors++; $display("FAIL flush_pre: got valid %b pc %h want 1 10", instr_valid, instr_pc); end
    flush = 1'b1; instr_ready = 1'b1;
    #1;
    n_checks++; if (pc_ready !== 1'b0) begin n_errors++; $display("FAIL flush_ready_low: got %b want 0", pc_ready); end
    tick();
    flush = 1'b0; instr_ready = 1'b0; pc_in = 8'h40; pc_valid = 1'b1;
    #1;
    n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL flush_valid: got %b want 0", instr_valid); end
    n_checks++; if (pc_ready !== 1'b1) begin n_errors++; $display("FAIL flush_ready_back: got %b want 1", pc_ready); end
    n_checks++; if (fetch_count !== 16'd20) begin n_errors++; $display("FAIL flush_keeps_count: got %0d want 20", fetch_count); end
    tick();
    pc_valid = 1'b0;
    n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL flush_s1_dropped: got %b want 0", instr_valid); end
    tick();
    n_checks++; if (instr_valid !== 1'b1) begin n_errors++; $display("FAIL flush_redirect_valid: got %b want 1", instr_valid); end
    n_checks++; if (instr_out !== 16'h40BF) begin n_errors++; $display("FAIL flush_redirect_instr: got %h want 40bf", instr_out); end
    n_checks++; if (instr_pc !== 8'h40) begin n_errors++; $display("FAIL flush_redirect_pc: got %h want 40", instr_pc); end
    instr_ready = 1'b1;
    tick();
    n_checks++; if (instr_valid !== 1'b0 || fetch_count !== 16'd21) begin n_errors++; $display("FAIL flush_after: got valid %b count %0d want 0 21", instr_valid, fetch_count); end
  endtask

  task automatic test_wrap();
    instr_ready = 1'b1; pc_in = 8'hFE; pc_valid = 1'b1;
    #1;
    tick();
    pc_in = 8'hFF;
    tick();
    n_checks++; if (instr_pc !== 8'hFE || instr_out !== 16'hFE01) begin n_errors++; $display("FAIL wrap_fe: got %h/%h want fe/fe01", instr_pc, instr_out); end
    pc_in = 8'h00;
    tick();
    n_checks++; if (instr_pc !== 8'hFF || instr_out !== 16'hFF00) begin n_errors++; $display("FAIL wrap_ff: got %h/%h want ff/ff00", instr_pc, instr_out); end
    pc_valid = 1'b0;
    tick();
    n_checks++; if (instr_pc !== 8'h00 || instr_out !== 16'h00FF || instr_valid !== 1'b1) begin n_errors++; $display("FAIL wrap_00: got %b %h/%h want 1 00/00ff", instr_valid, instr_pc, instr_out); end
    tick();
    n_checks++; if (instr_valid !== 1'b0 || fetch_count !== 16'd24) begin n_errors++; $display("FAIL wrap_end: got valid %b count %0d want 0 24", instr_valid, fetch_count); end
  endtask

  task automatic test_reset_mid();
    instr_ready = 1'b0; pc_in = 8'h20; pc_valid = 1'b1;
    #1;
    tick(); pc_in = 8'h21;
    tick(); pc_in = 8'h22;
    tick(); pc_valid = 1'b0;
    tick();
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 8'h20) begin n_errors++; $display("FAIL rmid_pre: got valid %b pc %h want 1 20", instr_valid, instr_pc); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (pc_ready !== 1'b0) begin n_errors++; $display("FAIL rmid_ready_in_reset: got %b want 0", pc_ready); end
    tick();
    n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL rmid_valid: got %b want 0", instr_valid); end
    n_checks++; if (instr_out !== 16'h0000 || instr_pc !== 8'h00) begin n_errors++; $display("FAIL rmid_data: got %h/%h want 0000/00", instr_out, instr_pc); end
    n_checks++; if (fetch_count !== 16'd0) begin n_errors++; $display("FAIL rmid_count: got %0d want 0", fetch_count); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (pc_ready !== 1'b1) begin n_errors++; $display("FAIL rmid_ready_after: got %b want 1", pc_ready); end
    tick();
    n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL rmid_s1_cleared: got %b want 0", instr_valid); end
  endtask

  task automatic test_counter();
    int n_acc;
    int cyc;
    n_acc = 0; cyc = 0;
    instr_ready = 1'b1; pc_in = 8'h00; pc_valid = 1'b1;
    #1;
    acc = pc_valid & pc_ready;
    while (n_acc < 65537 && cyc < 70000) begin
      tick();
      cyc++;
      if (acc) begin
        n_acc++;
        pc_in = pc_in + 8'd1;
      end
      if (n_acc == 65537) pc_valid = 1'b0;
      #1;
      acc = pc_valid & pc_ready;
    end
    n_checks++; if (n_acc !== 65537) begin n_errors++; $display("FAIL cnt_accepts: got %0d want 65537 within bound", n_acc); end
    tick(); tick(); tick();
    n_checks++; if (fetch_count !== 16'd1) begin n_errors++; $display("FAIL cnt_wrap: got %0d want 1", fetch_count); end
    n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL cnt_drained: got %b want 0", instr_valid); end
    pc_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      pc_in = pc_in + 8'd1;
    end
    pc_valid = 1'b0;
    tick(); tick(); tick();
    n_checks++; if (fetch_count !== 16'd5) begin n_errors++; $display("FAIL cnt_five: got %0d want 5", fetch_count); end
    instr_ready = 1'b0; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    tick(); tick();
    n_checks++; if (instr_valid !== 1'b1) begin n_errors++; $display("FAIL cnt_flush_pre: got %b want 1", instr_valid); end
    flush = 1'b1; instr_ready = 1'b1;
    tick();
    flush = 1'b0; instr_ready = 1'b0;
    n_checks++; if (fetch_count !== 16'd5) begin n_errors++; $display("FAIL cnt_flush_keeps: got %0d want 5", fetch_count); end
    n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL cnt_flush_empty: got %b want 0", instr_valid); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_wrap();
    test_reset_mid();
    test_counter();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
